// File: rtl/fetch_sequencer.sv
// Program-counter and instruction-fetch sequencer for the single-issue MIPS
// datapath. It fetches one instruction at a time over a req/ack handshake and
// holds it for decode. When decode consumes the instruction, it picks the next
// fetch address from the JR, J/JAL and branch redirects in that priority order.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nreset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic        instrValid,
    output logic [31:0] instruction,
    output logic [31:0] programCounter,
    output logic [31:0] linkAddress,
    input  logic        stall,
    input  logic        doesJump,
    input  logic [31:0] jumpAddress,
    input  logic        branchTaken,
    input  logic [15:0] branchImm,
    input  logic        jr,
    input  logic [31:0] jrAddress,
    output logic        misaligned,
    output logic [31:0] retiredCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [31:0] next_pc;
    logic [31:0] seq_pc;
    logic [31:0] branch_offset;
    logic        load_instr;
    logic        retire;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples its pre-edge value, independent of the order the blocks run in.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; the memory ack only counts while a request is out.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        load_instr = 1'b0;
        retire     = 1'b0;
        imemReq    = 1'b0;
        instrValid = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imemReq = 1'b1;
                if (imemAck) begin
                    load_instr = 1'b1;
                    state_next = VALID;
                end
            end
            VALID: begin
                instrValid = 1'b1;
                if (!stall) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Next-PC selection by fixed priority: JR, then J/JAL, then taken branch, then sequential.
    always_comb begin
        seq_pc        = programCounter + 32'd4;
        branch_offset = {{14{branchImm[15]}}, branchImm, 2'b00};
        if (jr) begin
            next_pc = {jrAddress[31:2], 2'b00};
        end else if (doesJump) begin
            next_pc = jumpAddress;
        end else if (branchTaken) begin
            next_pc = seq_pc + branch_offset;
        end else begin
            next_pc = seq_pc;
        end
    end

    // Fetch address, held instruction, retire counter and sticky misalignment flag.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fetch_pc       <= RESET_PC;
            instruction    <= 32'd0;
            programCounter <= 32'd0;
            retiredCount   <= 32'd0;
            misaligned     <= 1'b0;
        end else begin
            if (load_instr) begin
                instruction    <= imemData;
                programCounter <= fetch_pc;
            end
            if (retire) begin
                fetch_pc     <= next_pc;
                retiredCount <= retiredCount + 32'd1;
                if (jr && (jrAddress[1:0] != 2'b00)) begin
                    misaligned <= 1'b1;
                end
            end
        end
    end

    assign imemAddr    = fetch_pc;
    assign linkAddress = programCounter + 32'd4;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer. Inputs change 1 ns after
// the rising edge, and outputs are sampled at the same point, so all values are
// stable when read.
module tb_fetch_sequencer;

    logic        clk;
    logic        nreset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        instrValid;
    logic [31:0] instruction;
    logic [31:0] programCounter;
    logic [31:0] linkAddress;
    logic        stall;
    logic        doesJump;
    logic [31:0] jumpAddress;
    logic        branchTaken;
    logic [15:0] branchImm;
    logic        jr;
    logic [31:0] jrAddress;
    logic        misaligned;
    logic [31:0] retiredCount;

    int tests_run;
    int tests_failed;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .nreset         (nreset),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemAck        (imemAck),
        .imemData       (imemData),
        .instrValid     (instrValid),
        .instruction    (instruction),
        .programCounter (programCounter),
        .linkAddress    (linkAddress),
        .stall          (stall),
        .doesJump       (doesJump),
        .jumpAddress    (jumpAddress),
        .branchTaken    (branchTaken),
        .branchImm      (branchImm),
        .jr             (jr),
        .jrAddress      (jrAddress),
        .misaligned     (misaligned),
        .retiredCount   (retiredCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] addr);
        check({tag, " req"}, {31'd0, imemReq}, 32'd1);
        check({tag, " addr"}, imemAddr, addr);
        check({tag, " valid"}, {31'd0, instrValid}, 32'd0);
    endtask

    task automatic check_valid(input string tag, input logic [31:0] pc);
        check({tag, " valid"}, {31'd0, instrValid}, 32'd1);
        check({tag, " req"}, {31'd0, imemReq}, 32'd0);
        check({tag, " pc"}, programCounter, pc);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " req"}, {31'd0, imemReq}, 32'd0);
        check({tag, " addr"}, imemAddr, 32'd0);
        check({tag, " valid"}, {31'd0, instrValid}, 32'd0);
        check({tag, " instr"}, instruction, 32'd0);
        check({tag, " pc"}, programCounter, 32'd0);
        check({tag, " link"}, linkAddress, 32'd4);
        check({tag, " misal"}, {31'd0, misaligned}, 32'd0);
        check({tag, " retired"}, retiredCount, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        nreset      = 1'b0;
        imemAck     = 1'b1;
        imemData    = 32'h2001_0005;
        stall       = 1'b0;
        doesJump    = 1'b0;
        jumpAddress = 32'd0;
        branchTaken = 1'b0;
        branchImm   = 16'd0;
        jr          = 1'b0;
        jrAddress   = 32'd0;

        // Reset state, with an ack already present that must be ignored.
        #1;
        check_reset("rst");
        step();
        step();
        nreset = 1'b1;
        #1;
        check("rel idle req", {31'd0, imemReq}, 32'd0);

        // Zero-wait sequential fetch: 0, 4, then 8 with a delayed ack.
        step();
        check_fetch("f0", 32'h0);
        step();
        check_valid("v0", 32'h0);
        check("v0 instr", instruction, 32'h2001_0005);
        check("v0 link", linkAddress, 32'h4);
        step();
        check_fetch("f4", 32'h4);
        check("f4 retired", retiredCount, 32'd1);
        step();
        check_valid("v4", 32'h4);
        step();
        check_fetch("f8", 32'h8);
        check("f8 retired", retiredCount, 32'd2);

        // Ack withheld for three cycles at address 8.
        imemAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_fetch("wait8", 32'h8);
            check("wait8 retired", retiredCount, 32'd2);
        end
        imemAck = 1'b1;
        step();
        check_valid("v8", 32'h8);
        check("v8 retired", retiredCount, 32'd2);
        step();
        check_fetch("fc", 32'hC);
        check("three retired", retiredCount, 32'd3);
        step();
        check_valid("vc", 32'hC);
        step();
        check_fetch("f10", 32'h10);
        step();
        check_valid("v10", 32'h10);

        // Stall for four cycles with a jump offered; the jump must be ignored.
        stall       = 1'b1;
        doesJump    = 1'b1;
        jumpAddress = 32'h400;
        for (int i = 0; i < 4; i++) begin
            step();
            check_valid("stall", 32'h10);
            check("stall retired", retiredCount, 32'd4);
        end
        stall    = 1'b0;
        doesJump = 1'b0;
        step();
        check_fetch("after stall", 32'h14);
        check("after stall retired", retiredCount, 32'd5);

        // Jump to 0x100, then a backward branch to 0xFC.
        step();
        check_valid("v14", 32'h14);
        doesJump    = 1'b1;
        jumpAddress = 32'h100;
        step();
        check_fetch("jump", 32'h100);
        doesJump = 1'b0;
        step();
        check_valid("v100", 32'h100);
        branchTaken = 1'b1;
        branchImm   = 16'hFFFE;
        step();
        check_fetch("branch back", 32'hFC);
        branchTaken = 1'b0;
        step();
        check_valid("vfc", 32'hFC);
        step();
        check_fetch("f100 again", 32'h100);
        step();
        check_valid("v100 again", 32'h100);

        // All three redirects together: JR wins and flags misalignment.
        branchTaken = 1'b1;
        branchImm   = 16'hFFFE;
        doesJump    = 1'b1;
        jumpAddress = 32'h200;
        jr          = 1'b1;
        jrAddress   = 32'h303;
        step();
        check_fetch("jr prio", 32'h300);
        check("misal set", {31'd0, misaligned}, 32'd1);
        branchTaken = 1'b0;
        doesJump    = 1'b0;
        jr          = 1'b0;
        step();
        check_valid("v300", 32'h300);
        step();
        check_fetch("f304", 32'h304);
        check("misal sticky", {31'd0, misaligned}, 32'd1);

        // PC wrap: JR to 0xFFFF_FFFC, then the sequential fetch wraps to 0.
        step();
        check_valid("v304", 32'h304);
        jr        = 1'b1;
        jrAddress = 32'hFFFF_FFFC;
        step();
        check_fetch("f top", 32'hFFFF_FFFC);
        jr = 1'b0;
        step();
        check_valid("v top", 32'hFFFF_FFFC);
        check("wrap link", linkAddress, 32'h0);
        step();
        check_fetch("wrap", 32'h0);
        check("wrap retired", retiredCount, 32'd12);
        step();
        check_valid("v0 b", 32'h0);
        step();
        check_fetch("f4 b", 32'h4);

        // Reset during a pending fetch; an ack in the idle cycle is discarded.
        imemAck = 1'b0;
        step();
        check_fetch("pend", 32'h4);
        nreset = 1'b0;
        #1;
        check_reset("mid rst");
        step();
        nreset   = 1'b1;
        imemAck  = 1'b1;
        imemData = 32'hDEAD_BEEF;
        #1;
        check("post rst idle req", {31'd0, imemReq}, 32'd0);
        check("post rst idle valid", {31'd0, instrValid}, 32'd0);
        step();
        check_fetch("restart", 32'h0);
        check("restart instr", instruction, 32'h0);
        step();
        check_valid("restart v", 32'h0);
        check("restart data", instruction, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
